dsp_stage_scheduler: RTL and testbench
======================================

Name: dsp_stage_scheduler

Overview:
- Per-frame sequencer for the audio DSP datapath.
- Latches one stereo sample per LRCK-low half-frame.
- Routes the L channel, then the R channel, through the effect stages enabled in filter_select, in ascending stage order, over a shared req/ack stage bus.
- Applies volume gain, then presents the result to the codec-side output registers.

Parameters:
- DATA_W, 16, sample width, two's complement.
- NSTAGE, 4, number of effect stages on the shared bus; width of filter_select.
- GAIN_W, 4, width of the unsigned volume multiplier.
- TIMEOUT, 64, maximum cycles a stage request waits for ack before that stage is bypassed.

Ports:
- CLOCK_50  in  1  system clock.
- AUD_DACLRCK  in  1  reset: asynchronous, active-high; clock is CLOCK_50.
- DSP_enable  in  1  0 = pass-through; no stages, no gain.
- sample_valid  in  1  one-cycle strobe; audio_inL and audio_inR are valid.
- audio_inL, audio_inR  in  DATA_W  input samples.
- filter_select  in  NSTAGE  stage enable bitmap; bit k enables stage k.
- volume_scale  in  GAIN_W  unsigned gain; 0 = mute.
- stage_req  out  1  request to the stage bus.
- stage_id  out  clog2(NSTAGE)  stage addressed.
- stage_ch  out  1  0 = L, 1 = R.
- stage_data  out  DATA_W  operand to the stage.
- stage_ack  in  1  stage accepted the request; stage_result is valid.
- stage_result  in  DATA_W  stage output.
- DSP_outL, DSP_outR  out  DATA_W  processed samples.
- out_valid  out  1  one-cycle pulse; DSP_out* are valid.
- busy  out  1  high in every state except IDLE and HOLD.
- timeout_err  out  1  set if any stage timed out this frame.

Behaviour:
- Reset (AUD_DACLRCK high) clears everything asynchronously:
  - state = IDLE.
  - All outputs = 0, including DSP_out*, stage bus, out_valid, busy, timeout_err.
  - Reset mid-operation aborts the frame with no output.
- States: IDLE, REQ, GAIN, DONE, HOLD.
- IDLE, on sample_valid:
  - Latch audio_inL/R, filter_select, volume_scale and DSP_enable. Later input changes are ignored for this frame.
  - ch = L.
  - If DSP_enable and at least one bit is set: go to REQ at the lowest set stage. Otherwise go to GAIN.
- REQ:
  - stage_req = 1; stage_id, stage_ch and stage_data are held stable until the request ends.
  - On a cycle with stage_req and stage_ack both high: channel data <= stage_result. stage_req drops the next cycle.
  - If there is no ack after TIMEOUT cycles in REQ: drop stage_req, leave data unchanged, set timeout_err.
  - After each stage: move to the next higher set bit. If none remain: when ch = L, switch to ch = R at the lowest set bit; when ch = R, go to GAIN.
  - Zero idle cycles between back-to-back requests. stage_ack while stage_req is low is ignored.
- GAIN (one cycle, both channels):
  - If latched DSP_enable: out = signed data × unsigned volume_scale, width DATA_W+GAIN_W+1, reduced to DATA_W per DSP_SAT_EN.
  - If latched DSP_enable is 0: out = raw latched input.
- DONE:
  - DSP_out* registered; out_valid = 1 for exactly one cycle.
  - Then go to HOLD.
- HOLD:
  - DSP_out* hold their values until reset.
  - sample_valid is ignored. Only one frame is processed per reset-deassertion interval.
- Latency, sample_valid edge to out_valid high:
  - 3 cycles with no stages.
  - 3 + Σ(per-request cycles through ack) with stages.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro: DSP_SAT_EN.
- Defined: the gain product saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: the low DATA_W bits of the product are kept, so the result wraps.

Test Plan:
- DSP_enable=0, inL=0x1234, inR=0xFEDC, volume_scale=3 -> DSP_outL=0x1234, DSP_outR=0xFEDC; out_valid 3 cycles after sample_valid; stage_req never asserted.
- DSP_enable=1, filter_select=0, inL=0x0100, volume_scale=4 -> DSP_outL=0x0400; volume_scale=0 -> both outputs 0x0000.
- filter_select=4'b1010, stage model returns operand+1 with immediate ack -> request order (id,ch) = (1,L),(3,L),(1,R),(3,R); inL=5 with gain 1 -> DSP_outL=7.
- Stage 2 never acks, filter_select=4'b0100 -> stage_req high for exactly 64 cycles; data passes unchanged; timeout_err=1; out_valid follows.
- DSP_SAT_EN defined: inL=0x4000, gain 4 -> 0x7FFF; inR=0xC000, gain 4 -> 0x8000. Undefined: 0x4000×4 -> 0x0000.
- Assert AUD_DACLRCK while in REQ -> stage_req, busy and out_valid go to 0 immediately with no output pulse. A second sample_valid in HOLD is ignored.

Source files
------------

// File: rtl/dsp_stage_scheduler.sv
// dsp_stage_scheduler: per-frame sequencer for the audio DSP datapath.
// Latches one stereo sample, walks the L then R channel through the enabled
// effect stages on a shared req/ack bus, applies volume gain and presents the
// result once. Optional macro DSP_SAT_EN selects saturating gain; without it
// the gain product wraps to DATA_W bits.
//
// Stage bus handshake: stage_req is held high with stage_id, stage_ch and
// stage_data stable until a cycle where stage_req and stage_ack are both high
// (stage_result is taken on that cycle) or until TIMEOUT cycles pass without
// ack. The next request may start on the following cycle with no gap.
// stage_ack while stage_req is low has no effect.
module dsp_stage_scheduler #(
   parameter int DATA_W  = 16,
   parameter int NSTAGE  = 4,
   parameter int GAIN_W  = 4,
   parameter int TIMEOUT = 64,
   localparam int ID_W   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
   input  logic              CLOCK_50,
   input  logic              AUD_DACLRCK,
   input  logic              DSP_enable,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] audio_inL,
   input  logic [DATA_W-1:0] audio_inR,
   input  logic [NSTAGE-1:0] filter_select,
   input  logic [GAIN_W-1:0] volume_scale,
   output logic              stage_req,
   output logic [ID_W-1:0]   stage_id,
   output logic              stage_ch,
   output logic [DATA_W-1:0] stage_data,
   input  logic              stage_ack,
   input  logic [DATA_W-1:0] stage_result,
   output logic [DATA_W-1:0] DSP_outL,
   output logic [DATA_W-1:0] DSP_outR,
   output logic              out_valid,
   output logic              busy,
   output logic              timeout_err,
   output logic [2:0]        state_dbg
);

   localparam int PW    = DATA_W + GAIN_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      GAIN = 3'd2,
      DONE = 3'd3,
      HOLD = 3'd4
   } state_t;

   state_t            state;
   logic [NSTAGE-1:0] mask_r;
   logic [GAIN_W-1:0] vol_r;
   logic              en_r;
   logic [DATA_W-1:0] data_l, data_r;
   logic [DATA_W-1:0] res_l, res_r;
   logic [TMO_W-1:0]  tmo_cnt;

   logic              hit, expired, adv;
   logic [DATA_W-1:0] cur_new;
   logic [ID_W:0]     nxt_hi, low_latched, first_in;

   // {found, index} of the lowest set bit of m
   function automatic logic [ID_W:0] lowest_bit(input logic [NSTAGE-1:0] m);
      logic [ID_W:0] r;
      r = '0;
      for (int k = NSTAGE - 1; k >= 0; k--)
         if (m[k]) r = {1'b1, ID_W'(k)};
      return r;
   endfunction

   // {found, index} of the lowest set bit of m strictly above cur
   function automatic logic [ID_W:0] next_above(input logic [NSTAGE-1:0] m,
                                                input logic [ID_W-1:0] cur);
      logic [ID_W:0] r;
      r = '0;
      for (int k = NSTAGE - 1; k >= 0; k--)
         if (m[k] && (k > int'(cur))) r = {1'b1, ID_W'(k)};
      return r;
   endfunction

   // signed sample times unsigned gain, reduced back to DATA_W
   function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] d,
                                                    input logic [GAIN_W-1:0] g);
      logic signed [PW-1:0] ds, gs, p;
      ds = PW'($signed(d));
      gs = PW'({1'b0, g});
      p  = ds * gs;
`ifdef DSP_SAT_EN
      if (p[PW-1] && !(&p[PW-1:DATA_W-1]))
         return {1'b1, {(DATA_W-1){1'b0}}};
      else if (!p[PW-1] && (|p[PW-1:DATA_W-1]))
         return {1'b0, {(DATA_W-1){1'b1}}};
      else
         return p[DATA_W-1:0];
`else
      return p[DATA_W-1:0];
`endif
   endfunction

   // request completion and next-stage selection
   always_comb begin
      hit         = stage_req && stage_ack;
      expired     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
      adv         = (state == REQ) && (hit || expired);
      cur_new     = hit ? stage_result : stage_data;
      nxt_hi      = next_above(mask_r, stage_id);
      low_latched = lowest_bit(mask_r);
      first_in    = lowest_bit(filter_select);
   end

   assign state_dbg = state;

   // frame sequencer with registered outputs
   always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
      if (AUD_DACLRCK) begin
         state       <= IDLE;
         mask_r      <= '0;
         vol_r       <= '0;
         en_r        <= 1'b0;
         data_l      <= '0;
         data_r      <= '0;
         res_l       <= '0;
         res_r       <= '0;
         tmo_cnt     <= '0;
         stage_req   <= 1'b0;
         stage_id    <= '0;
         stage_ch    <= 1'b0;
         stage_data  <= '0;
         DSP_outL    <= '0;
         DSP_outR    <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sample_valid) begin
                  mask_r   <= filter_select;
                  vol_r    <= volume_scale;
                  en_r     <= DSP_enable;
                  data_l   <= audio_inL;
                  data_r   <= audio_inR;
                  stage_ch <= 1'b0;
                  tmo_cnt  <= '0;
                  busy     <= 1'b1;
                  if (DSP_enable && first_in[ID_W]) begin
                     state      <= REQ;
                     stage_req  <= 1'b1;
                     stage_id   <= first_in[ID_W-1:0];
                     stage_data <= audio_inL;
                  end else begin
                     state <= GAIN;
                  end
               end
            end
            REQ: begin
               if (adv) begin
                  tmo_cnt <= '0;
                  if (!hit) timeout_err <= 1'b1;
                  if (stage_ch) data_r <= cur_new;
                  else          data_l <= cur_new;
                  if (nxt_hi[ID_W]) begin
                     stage_id   <= nxt_hi[ID_W-1:0];
                     stage_data <= cur_new;
                  end else if (!stage_ch) begin
                     stage_ch   <= 1'b1;
                     stage_id   <= low_latched[ID_W-1:0];
                     stage_data <= data_r;
                  end else begin
                     stage_req <= 1'b0;
                     state     <= GAIN;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            GAIN: begin
               res_l <= en_r ? apply_gain(data_l, vol_r) : data_l;
               res_r <= en_r ? apply_gain(data_r, vol_r) : data_r;
               state <= DONE;
            end
            DONE: begin
               DSP_outL  <= res_l;
               DSP_outR  <= res_r;
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= HOLD;
            end
            HOLD: begin
               out_valid <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               stage_req <= 1'b0;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_stage_scheduler.sv
// Testbench for dsp_stage_scheduler: directed frames, scoreboard queues for
// outputs and stage-bus requests, and a final report.
module tb_dsp_stage_scheduler;

   localparam int DW = 16;
   localparam int NS = 4;
   localparam int GW = 4;

   logic          CLOCK_50;
   logic          AUD_DACLRCK;
   logic          DSP_enable;
   logic          sample_valid;
   logic [DW-1:0] audio_inL, audio_inR;
   logic [NS-1:0] filter_select;
   logic [GW-1:0] volume_scale;
   logic          stage_req;
   logic [1:0]    stage_id;
   logic          stage_ch;
   logic [DW-1:0] stage_data;
   logic          stage_ack;
   logic [DW-1:0] stage_result;
   logic [DW-1:0] DSP_outL, DSP_outR;
   logic          out_valid, busy, timeout_err;
   logic [2:0]    state_dbg;

   int ack_mode;
   int cyc, sv_cyc, last_lat, out_cnt;
   int req_hi_l, req_hi_r;
   bit req_seen;
   int n_checks, n_fail;

   logic [2*DW-1:0] exp_q[$];
   logic [2:0]      req_q[$];

   dsp_stage_scheduler dut (
      .CLOCK_50      (CLOCK_50),
      .AUD_DACLRCK   (AUD_DACLRCK),
      .DSP_enable    (DSP_enable),
      .sample_valid  (sample_valid),
      .audio_inL     (audio_inL),
      .audio_inR     (audio_inR),
      .filter_select (filter_select),
      .volume_scale  (volume_scale),
      .stage_req     (stage_req),
      .stage_id      (stage_id),
      .stage_ch      (stage_ch),
      .stage_data    (stage_data),
      .stage_ack     (stage_ack),
      .stage_result  (stage_result),
      .DSP_outL      (DSP_outL),
      .DSP_outR      (DSP_outR),
      .out_valid     (out_valid),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .state_dbg     (state_dbg)
   );

   // stage model: mode 0 acks immediately and returns operand+1, mode 1 never acks
   assign stage_ack    = (ack_mode == 0) ? stage_req : 1'b0;
   assign stage_result = stage_data + 16'd1;

   // clock / cycle counter
   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: sample on the falling edge, compare against the queues
   always @(negedge CLOCK_50) begin
      if (stage_req) begin
         req_seen = 1'b1;
         if (stage_ch) req_hi_r++;
         else          req_hi_l++;
      end
      if (stage_req && stage_ack) begin
         if (req_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: got id=%0d ch=%0d expected none", stage_id, stage_ch);
         end else begin
            chk("req_order", {29'd0, stage_id, stage_ch}, {29'd0, req_q.pop_front()});
         end
      end
      if (out_valid) begin
         out_cnt++;
         last_lat = cyc - sv_cyc;
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_out: got %h_%h expected none", DSP_outL, DSP_outR);
         end else begin
            chk("dsp_out", {DSP_outL, DSP_outR}, exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      AUD_DACLRCK = 1'b1;
      sample_valid = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      #2;
      exp_q.delete();
      req_q.delete();
      req_hi_l = 0;
      req_hi_r = 0;
      req_seen = 1'b0;
      AUD_DACLRCK = 1'b0;
   endtask

   task automatic drive_sample(input logic en, input logic [DW-1:0] l, input logic [DW-1:0] r,
                               input logic [NS-1:0] fs, input logic [GW-1:0] vol);
      @(posedge CLOCK_50); #2;
      DSP_enable = en; audio_inL = l; audio_inR = r;
      filter_select = fs; volume_scale = vol;
      sample_valid = 1'b1;
      sv_cyc = cyc;
      @(posedge CLOCK_50); #2;
      sample_valid = 1'b0;
      DSP_enable = ~en; audio_inL = ~l; audio_inR = ~r;
      filter_select = ~fs; volume_scale = ~vol;
   endtask

   task automatic run_frame(input string nm, input logic en, input logic [DW-1:0] l,
                            input logic [DW-1:0] r, input logic [NS-1:0] fs,
                            input logic [GW-1:0] vol, input int exp_lat);
      int base;
      base = out_cnt;
      drive_sample(en, l, r, fs, vol);
      for (int i = 0; i < 300 && out_cnt == base; i++) @(posedge CLOCK_50);
      #2;
      chk({nm, "_done"}, out_cnt - base, 1);
      chk({nm, "_latency"}, last_lat, exp_lat);
      chk({nm, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int base;
      n_checks = 0; n_fail = 0; cyc = 0; out_cnt = 0; ack_mode = 0;
      sv_cyc = 0; last_lat = 0;
      DSP_enable = 0; audio_inL = 0; audio_inR = 0; filter_select = 0; volume_scale = 0;
      do_reset();

      // reset state
      @(negedge CLOCK_50);
      chk("rst_outL", DSP_outL, 0);
      chk("rst_outR", DSP_outR, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_stage_req", stage_req, 0);
      chk("rst_stage_data", stage_data, 0);
      chk("rst_state", state_dbg, 0);

      // pass-through: stages and gain ignored
      exp_q.push_back({16'h1234, 16'hFEDC});
      run_frame("bypass", 1'b0, 16'h1234, 16'hFEDC, 4'hF, 4'd3, 3);
      chk("bypass_no_req", req_seen, 0);
      chk("bypass_busy", busy, 0);
      chk("bypass_hold_state", state_dbg, 4);

      // a second sample in HOLD is ignored
      base = out_cnt;
      drive_sample(1'b1, 16'h0555, 16'h0AAA, 4'h0, 4'd1);
      repeat (10) @(posedge CLOCK_50);
      #2;
      chk("hold_no_output", out_cnt - base, 0);
      chk("hold_outL", DSP_outL, 16'h1234);
      chk("hold_outR", DSP_outR, 16'hFEDC);

      // gain only
      do_reset();
      exp_q.push_back({16'h0400, 16'h0040});
      run_frame("gain4", 1'b1, 16'h0100, 16'h0010, 4'h0, 4'd4, 3);
      do_reset();
      exp_q.push_back({16'h0000, 16'h0000});
      run_frame("mute", 1'b1, 16'h0100, 16'h7FFF, 4'h0, 4'd0, 3);

      // stages 1 and 3, immediate ack, operand+1
      do_reset();
      req_q.push_back(3'b010); req_q.push_back(3'b110);
      req_q.push_back(3'b011); req_q.push_back(3'b111);
      exp_q.push_back({16'h0007, 16'hFFFF});
      run_frame("stages", 1'b1, 16'h0005, 16'hFFFD, 4'b1010, 4'd1, 7);
      chk("stages_req_done", req_q.size(), 0);
      chk("stages_no_timeout", timeout_err, 0);

      // stage 2 never acks: each request times out after 64 cycles
      do_reset();
      ack_mode = 1;
      exp_q.push_back({16'h0022, 16'h0044});
      run_frame("timeout", 1'b1, 16'h0011, 16'h0022, 4'b0100, 4'd2, 131);
      chk("timeout_req_cycles_L", req_hi_l, 64);
      chk("timeout_req_cycles_R", req_hi_r, 64);
      chk("timeout_err_set", timeout_err, 1);
      ack_mode = 0;

      // gain overflow
      do_reset();
`ifdef DSP_SAT_EN
      exp_q.push_back({16'h7FFF, 16'h8000});
`else
      exp_q.push_back({16'h0000, 16'h0000});
`endif
      run_frame("overflow", 1'b1, 16'h4000, 16'hC000, 4'h0, 4'd4, 3);

      // reset while a request is pending aborts the frame
      do_reset();
      ack_mode = 1;
      base = out_cnt;
      drive_sample(1'b1, 16'h0101, 16'h0202, 4'b0001, 4'd1);
      repeat (5) @(posedge CLOCK_50);
      #3;
      chk("abort_pre_req", stage_req, 1);
      chk("abort_pre_busy", busy, 1);
      AUD_DACLRCK = 1'b1;
      #1;
      chk("abort_req", stage_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_state", state_dbg, 0);
      repeat (2) @(posedge CLOCK_50);
      #2;
      AUD_DACLRCK = 1'b0;
      repeat (80) @(posedge CLOCK_50);
      #2;
      chk("abort_no_output", out_cnt - base, 0);
      chk("abort_timeout_err", timeout_err, 0);
      ack_mode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
